// File: rtl/mcdf_pkg.sv
// Shared constants, FSM state type and packet-length decode for the MCDF arbiter.
package mcdf_pkg;

    localparam int unsigned NUM_CH     = 3;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LEN_CODE_W = 3;
    localparam int unsigned LEN_W      = 6;
    localparam int unsigned ID_W       = 2;
    localparam int unsigned PRIO_W     = 2;

    typedef enum logic [0:0] {
        StIdle,
        StXfer
    } arb_state_e;

    // Codes 3..7 all mean the maximum packet of 32 words.
    function automatic logic [LEN_W-1:0] decode_len(input logic [LEN_CODE_W-1:0] code);
        case (code)
            3'd0:    return LEN_W'(4);
            3'd1:    return LEN_W'(8);
            3'd2:    return LEN_W'(16);
            default: return LEN_W'(32);
        endcase
    endfunction

endpackage

// File: rtl/mcdf_arbiter_if.sv
// Channel-side and formatter-side signal bundle of the MCDF arbiter.
interface mcdf_arbiter_if;
    import mcdf_pkg::*;

    logic                  slv0_req_i, slv1_req_i, slv2_req_i;
    logic                  slv0_val_i, slv1_val_i, slv2_val_i;
    logic [DATA_W-1:0]     slv0_data_i, slv1_data_i, slv2_data_i;
    logic [PRIO_W-1:0]     slv0_prio_i, slv1_prio_i, slv2_prio_i;
    logic [LEN_CODE_W-1:0] slv0_len_i, slv1_len_i, slv2_len_i;
    logic                  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o;

    logic                  f2a_id_req_i;
    logic                  f2a_ack_i;
    logic                  a2f_val_o;
    logic [DATA_W-1:0]     a2f_data_o;
    logic [ID_W-1:0]       a2f_id_o;
    logic [LEN_W-1:0]      a2f_len_o;
    logic                  a2f_start_o;
    logic                  a2f_end_o;

    modport master (
        input  slv0_req_i, slv1_req_i, slv2_req_i,
        input  slv0_val_i, slv1_val_i, slv2_val_i,
        input  slv0_data_i, slv1_data_i, slv2_data_i,
        input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
        input  slv0_len_i, slv1_len_i, slv2_len_i,
        output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
        input  f2a_id_req_i, f2a_ack_i,
        output a2f_val_o, a2f_data_o, a2f_id_o, a2f_len_o, a2f_start_o, a2f_end_o
    );

    modport slave (
        output slv0_req_i, slv1_req_i, slv2_req_i,
        output slv0_val_i, slv1_val_i, slv2_val_i,
        output slv0_data_i, slv1_data_i, slv2_data_i,
        output slv0_prio_i, slv1_prio_i, slv2_prio_i,
        output slv0_len_i, slv1_len_i, slv2_len_i,
        input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
        output f2a_id_req_i, f2a_ack_i,
        input  a2f_val_o, a2f_data_o, a2f_id_o, a2f_len_o, a2f_start_o, a2f_end_o
    );

endinterface

// File: rtl/mcdf_arb_pick.sv
// Combinational winner selection: lowest priority value, ties resolved round-robin
// starting at the channel after last_id_i.
module mcdf_arb_pick
    import mcdf_pkg::*;
(
    input  logic [NUM_CH-1:0]             req_i,
    input  logic [NUM_CH-1:0][PRIO_W-1:0] prio_i,
    input  logic [ID_W-1:0]               last_id_i,
    output logic                          valid_o,
    output logic [ID_W-1:0]               id_o
);

    logic [PRIO_W-1:0] min_prio;
    logic [ID_W-1:0]   cand;

    always_comb begin
        min_prio = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_i[i] && (prio_i[i] < min_prio)) begin
                min_prio = prio_i[i];
            end
        end

        valid_o = 1'b0;
        id_o    = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = ID_W'((int'(last_id_i) + k) % NUM_CH);
            if (!valid_o && req_i[cand] && (prio_i[cand] == min_prio)) begin
                valid_o = 1'b1;
                id_o    = cand;
            end
        end
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: grants one of three channel FIFOs to the formatter and streams one
// whole packet of the granted channel before arbitrating again.
module mcdf_arbiter
    import mcdf_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    mcdf_arbiter_if.master arb
);

    arb_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  last_q, last_d;

    logic [NUM_CH-1:0]                 req_vec, val_vec, ack_vec;
    logic [NUM_CH-1:0][PRIO_W-1:0]     prio_vec;
    logic [NUM_CH-1:0][LEN_CODE_W-1:0] len_code_vec;
    logic [NUM_CH-1:0][DATA_W-1:0]     data_vec;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [LEN_W-1:0]  grant_len;
    logic              sel_val;
    logic [DATA_W-1:0] sel_data;
    logic              start_word, end_word;

    assign req_vec      = {arb.slv2_req_i, arb.slv1_req_i, arb.slv0_req_i};
    assign val_vec      = {arb.slv2_val_i, arb.slv1_val_i, arb.slv0_val_i};
    assign prio_vec     = {arb.slv2_prio_i, arb.slv1_prio_i, arb.slv0_prio_i};
    assign len_code_vec = {arb.slv2_len_i, arb.slv1_len_i, arb.slv0_len_i};
    assign data_vec     = {arb.slv2_data_i, arb.slv1_data_i, arb.slv0_data_i};

    mcdf_arb_pick u_pick (
        .req_i     (req_vec),
        .prio_i    (prio_vec),
        .last_id_i (last_q),
        .valid_o   (pick_valid),
        .id_o      (pick_id)
    );

    assign grant_len = decode_len(len_code_vec[pick_id]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        id_d       = id_q;
        last_d     = last_q;
        sel_val    = 1'b0;
        sel_data   = '0;
        ack_vec    = '0;
        start_word = 1'b0;
        end_word   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb.f2a_id_req_i && pick_valid) begin
                    state_d = StXfer;
                    id_d    = pick_id;
                    last_d  = pick_id;
                    len_d   = grant_len;
                    cnt_d   = grant_len;
                end
            end
            StXfer: begin
                sel_val          = val_vec[id_q];
                sel_data         = data_vec[id_q];
                ack_vec[id_q]    = arb.f2a_ack_i;
                start_word       = sel_val && (cnt_q == len_q);
                end_word         = sel_val && (cnt_q == LEN_W'(1));
                if (sel_val && arb.f2a_ack_i) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    // Last word leaves: clear the packet context so IDLE outputs read 0.
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        len_d   = '0;
                        id_d    = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign arb.a2s0_ack_o  = ack_vec[0];
    assign arb.a2s1_ack_o  = ack_vec[1];
    assign arb.a2s2_ack_o  = ack_vec[2];
    assign arb.a2f_val_o   = sel_val;
    assign arb.a2f_data_o  = sel_data;
    assign arb.a2f_id_o    = id_q;
    assign arb.a2f_len_o   = len_q;
    assign arb.a2f_start_o = start_word;
    assign arb.a2f_end_o   = end_word;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed self-checking bench for mcdf_arbiter with a simple per-channel FIFO model.
module tb_mcdf_arbiter;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    mcdf_arbiter_if bus ();

    mcdf_arbiter dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .arb   (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned fifo_idx [3];

    function automatic logic [31:0] exp_word(input int ch, input int idx);
        return {4'hA, 4'(ch), 24'(idx)};
    endfunction

    function automatic logic [2:0] acks();
        return {bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o};
    endfunction

    function automatic logic [2:0] vals();
        return {bus.slv2_val_i, bus.slv1_val_i, bus.slv0_val_i};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_data();
        bus.slv0_data_i = exp_word(0, int'(fifo_idx[0]));
        bus.slv1_data_i = exp_word(1, int'(fifo_idx[1]));
        bus.slv2_data_i = exp_word(2, int'(fifo_idx[2]));
    endtask

    task automatic set_ch(input int ch, input logic req, input logic [1:0] prio,
                          input logic [2:0] len);
        case (ch)
            0: begin bus.slv0_req_i = req; bus.slv0_prio_i = prio; bus.slv0_len_i = len; end
            1: begin bus.slv1_req_i = req; bus.slv1_prio_i = prio; bus.slv1_len_i = len; end
            default: begin
                bus.slv2_req_i = req; bus.slv2_prio_i = prio; bus.slv2_len_i = len;
            end
        endcase
    endtask

    task automatic set_val(input int ch, input logic v);
        case (ch)
            0:       bus.slv0_val_i = v;
            1:       bus.slv1_val_i = v;
            default: bus.slv2_val_i = v;
        endcase
    endtask

    // One clock: pop the channel FIFOs that are being acked, then present the new heads.
    task automatic tick();
        logic [2:0] pop;
        pop = acks() & vals();
        @(posedge clk_i);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (pop[c]) fifo_idx[c]++;
        end
        set_data();
    endtask

    task automatic expect_grant(input string tag, input int id, input int len);
        int k;
        k = 0;
        while (bus.a2f_len_o == 6'd0 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, " grant_seen"}, 32'(k < 20), 32'd1);
        chk({tag, " id"}, 32'(bus.a2f_id_o), 32'(id));
        chk({tag, " len"}, 32'(bus.a2f_len_o), 32'(len));
    endtask

    task automatic stream(input string tag, input int id, input int n, input bit tog,
                          input int gap_at, input int stop_at);
        int   words, cyc, gap, base;
        logic v;
        words = 0;
        cyc   = 0;
        gap   = 0;
        base  = int'(fifo_idx[id]);
        while (words < n && words < stop_at && cyc < 300) begin
            bus.f2a_ack_i = tog ? logic'(cyc % 2 == 1) : 1'b1;
            v = !(words == gap_at && gap < 3);
            if (!v) gap++;
            set_val(id, v);
            #1;
            chk({tag, " val"}, 32'(bus.a2f_val_o), 32'(v));
            chk({tag, " other_acks"}, 32'(acks() & ~(3'b001 << id)), 32'd0);
            if (bus.a2f_val_o && bus.f2a_ack_i) begin
                chk({tag, " data"}, bus.a2f_data_o, exp_word(id, base + words));
                chk({tag, " start"}, 32'(bus.a2f_start_o), 32'(words == 0));
                chk({tag, " end"}, 32'(bus.a2f_end_o), 32'(words == n - 1));
                words++;
            end
            tick();
            cyc++;
        end
        set_val(id, 1'b1);
        bus.f2a_ack_i = 1'b1;
        chk({tag, " words"}, 32'(words), 32'((n < stop_at) ? n : stop_at));
        if (stop_at >= n) chk({tag, " idle_after_end"}, 32'(bus.a2f_len_o), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " val"}, 32'(bus.a2f_val_o), 32'd0);
        chk({tag, " data"}, bus.a2f_data_o, 32'd0);
        chk({tag, " id"}, 32'(bus.a2f_id_o), 32'd0);
        chk({tag, " len"}, 32'(bus.a2f_len_o), 32'd0);
        chk({tag, " start"}, 32'(bus.a2f_start_o), 32'd0);
        chk({tag, " end"}, 32'(bus.a2f_end_o), 32'd0);
        chk({tag, " acks"}, 32'(acks()), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            fifo_idx[c] = 0;
            set_ch(c, 1'b0, 2'd0, 3'd0);
            set_val(c, 1'b1);
        end
        set_data();
        bus.f2a_id_req_i = 1'b1;
        bus.f2a_ack_i    = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst_i = 1'b0;

        // Single requester ch1, 4-word packet
        set_ch(1, 1'b1, 2'd0, 3'd0);
        expect_grant("single", 1, 4);
        stream("single", 1, 4, 1'b0, -1, 99);

        // id_req gating: no grant while formatter is busy, XFER one cycle after request
        bus.f2a_id_req_i = 1'b0;
        repeat (5) tick();
        chk("gate held_idle", 32'(bus.a2f_len_o), 32'd0);
        bus.f2a_id_req_i = 1'b1;
        #1;
        chk("gate same_cycle", 32'(bus.a2f_len_o), 32'd0);
        tick();
        chk("gate one_cycle_len", 32'(bus.a2f_len_o), 32'd4);
        chk("gate one_cycle_id", 32'(bus.a2f_id_o), 32'd1);
        stream("gate", 1, 4, 1'b0, -1, 99);

        // Priority: ch2 (prio 1) beats ch0 (prio 2); requests dropped mid-packet
        set_ch(1, 1'b0, 2'd0, 3'd0);
        set_ch(0, 1'b1, 2'd2, 3'd0);
        set_ch(2, 1'b1, 2'd1, 3'd0);
        expect_grant("prio_first", 2, 4);
        set_ch(2, 1'b0, 2'd0, 3'd3);
        bus.f2a_id_req_i = 1'b0;
        stream("prio_first", 2, 4, 1'b0, -1, 99);
        bus.f2a_id_req_i = 1'b1;
        expect_grant("prio_next", 0, 4);
        stream("prio_next", 0, 4, 1'b0, -1, 99);

        // 32-word packet with toggling ack and a 3-cycle val gap
        set_ch(0, 1'b1, 2'd0, 3'd5);
        expect_grant("long", 0, 32);
        set_ch(0, 1'b1, 2'd3, 3'd0);
        stream("long", 0, 32, 1'b1, 10, 99);

        // Reset after word 3 of a 16-word packet
        set_ch(0, 1'b1, 2'd0, 3'd2);
        expect_grant("abort", 0, 16);
        stream("abort", 0, 16, 1'b0, -1, 3);
        rst_i = 1'b1;
        #1;
        chk_all_zero("abort_rst");
        tick();
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 2'd0, 3'd0);
        expect_grant("after_rst", 0, 4);
        stream("after_rst", 0, 4, 1'b0, -1, 99);

        // Round-robin from a fresh pointer: 0,1,2,0,1,2
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_grant("rr", i % 3, 4);
            stream("rr", i % 3, 4, 1'b0, -1, 99);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mcdf_arbiter.md
MCDF_ARBITER -- requirements
Module: mcdf_arbiter

Interface
REQ-001 SHALL provide port clk_i input 1: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_i input 1: reset, asynchronous, active-high.
REQ-003 SHALL provide, for each N in 0..2, port slvN_req_i input 1: channel N is enabled and holds at least one full packet.
REQ-004 SHALL provide slvN_val_i input 1: channel N FIFO head word valid.
REQ-005 SHALL provide slvN_data_i input 32: channel N FIFO head word.
REQ-006 SHALL provide slvN_prio_i input 2: channel N priority; 0 is highest.
REQ-007 SHALL provide slvN_len_i input 3: channel N packet-length code.
REQ-008 SHALL provide a2sN_ack_o output 1: pop strobe to channel N; the word is consumed when a2sN_ack_o and slvN_val_i are both 1.
REQ-009 SHALL provide f2a_id_req_i input 1: formatter idle and requesting the next packet.
REQ-010 SHALL provide f2a_ack_i input 1: formatter accepts the presented word this cycle.
REQ-011 SHALL provide a2f_val_o output 1, a2f_data_o output 32, a2f_id_o output 2, a2f_len_o output 6, a2f_start_o output 1 and a2f_end_o output 1: packet stream to the formatter.

Function
REQ-012 SHALL implement FSM states IDLE and XFER; reset state IDLE.
REQ-013 In IDLE, SHALL evaluate arbitration every cycle; if f2a_id_req_i=1 and any slvN_req_i=1, SHALL latch the winner id, decoded length and word counter, then enter XFER on the next edge.
REQ-014 Winner SHALL be the requester with the lowest slvN_prio_i value.
REQ-015 Priority ties SHALL be broken round-robin, starting at the channel after the last granted id; the last-granted pointer resets to 2, so ch0 wins first.
REQ-016 Length decode SHALL be: code 0->4, 1->8, 2->16, 3..7->32 words; a2f_len_o SHALL carry the decoded value.
REQ-017 slvN_prio_i and slvN_len_i SHALL be sampled only at grant; changes during XFER SHALL be ignored.
REQ-018 In XFER, a2f_data_o and a2f_val_o SHALL combinationally follow the granted channel's data and val.
REQ-019 In XFER, a2sG_ack_o SHALL equal f2a_ack_i for the granted channel G; all other acks SHALL be 0.
REQ-020 A word SHALL transfer in a cycle only when a2f_val_o and f2a_ack_i are both 1; each transfer decrements the counter.
REQ-021 a2f_start_o SHALL be 1 with the first word of a packet while it is presented.
REQ-022 a2f_end_o SHALL be 1 while the last word (counter = 1) is presented; its transfer returns the FSM to IDLE.
REQ-023 A packet SHALL stall with counter held, and without word loss or duplication, when slvG_val_i=0 or f2a_ack_i=0.
REQ-024 Deassertion of slvN_req_i or f2a_id_req_i during XFER SHALL NOT abort the packet.
REQ-025 a2f_id_o and a2f_len_o SHALL be registered at grant, held through XFER, and 0 in IDLE.
REQ-026 A new grant SHALL NOT occur in the cycle the end word transfers; minimum one IDLE cycle between packets.

Reset
REQ-027 On rst_i=1, the FSM SHALL go to IDLE, the counter SHALL be 0, the round-robin pointer SHALL be 2, and all outputs SHALL be 0, within the same cycle, asynchronously.
REQ-028 Reset mid-packet SHALL abandon the packet without asserting a2f_end_o; after reset release, normal arbitration SHALL resume.

Structure
REQ-029 Package mcdf_pkg SHALL hold NUM_CH=3, the data/length/id width constants, the arb_state_e enum and the length-decode function.
REQ-030 The combinational priority-plus-round-robin selection SHALL be the sub-module mcdf_arb_pick, with inputs req, prio and last id, and outputs valid and id.

Verification
REQ-031 Only ch1 requesting, prio 0, len code 0, val and ack held 1 -> 4 words, id=1, len=4; start on word 1, end on word 4; back to IDLE.
REQ-032 ch0 prio 2, ch2 prio 1, both requesting -> ch2 granted first, ch0 granted next.
REQ-033 All three requesting at prio 0 continuously -> grant order 0,1,2,0,1,2.
REQ-034 ch0 len code 5, f2a_ack_i toggling every cycle and val dropped for 3 cycles mid-packet -> exactly 32 words transferred in order, no duplicates.
REQ-035 rst_i asserted after word 3 of a 16-word packet -> all outputs 0 immediately and no end; after release, ch0 is granted first.
REQ-036 f2a_id_req_i=0 while requests are pending -> no grant; f2a_id_req_i=1 -> XFER one cycle later.
